// File: rtl/sw_led_ctrl.sv
// sw_led_ctrl: debounced switches driving LEDs in direct, toggle, blink or inverted mode.
// Blink hardware is built only when macro SW_LED_BLINK_EN is defined.
module sw_led_ctrl #(
    parameter int N_CH      = 4,
    parameter int DB_CYCLES = 16,
    parameter int BLINK_DIV = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] sw,
    input  logic [1:0]      mode,
    output logic [N_CH-1:0] led,
    output logic [N_CH-1:0] chg
);

    localparam int            CW       = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [N_CH-1:0] s1;
    logic [N_CH-1:0] sync;
    logic [N_CH-1:0] db;
    logic [N_CH-1:0] t;
    logic [N_CH-1:0] db_nx;
    logic [N_CH-1:0] t_nx;
    logic [N_CH-1:0] chg_nx;
    logic [N_CH-1:0] blk;
    logic [N_CH-1:0] led_nx;
    logic [CW-1:0]   cnt    [N_CH];
    logic [CW-1:0]   cnt_nx [N_CH];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= '0;
            sync <= '0;
        end else begin
            s1   <= sw;
            sync <= s1;
        end
    end

    // A mismatch must persist DB_CYCLES clocks before db follows sync
    always_comb begin
        db_nx  = db;
        t_nx   = t;
        chg_nx = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_nx[i] = '0;
            if (sync[i] != db[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    db_nx[i]  = sync[i];
                    chg_nx[i] = 1'b1;
                    if (sync[i])
                        t_nx[i] = ~t[i];
                end else begin
                    cnt_nx[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db  <= '0;
            t   <= '0;
            chg <= '0;
            for (int i = 0; i < N_CH; i++)
                cnt[i] <= '0;
        end else begin
            db  <= db_nx;
            t   <= t_nx;
            chg <= chg_nx;
            for (int i = 0; i < N_CH; i++)
                cnt[i] <= cnt_nx[i];
        end
    end

`ifdef SW_LED_BLINK_EN
    localparam int            BW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] bcnt;
    logic          ph;

    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt <= '0;
            ph   <= 1'b0;
        end else if (bcnt == BLINK_LAST) begin
            bcnt <= '0;
            ph   <= ~ph;
        end else begin
            bcnt <= bcnt + 1'b1;
        end
    end

    assign blk = db & {N_CH{ph}};
`else
    assign blk = db;
`endif

    always_comb begin
        led_nx = db;
        unique case (mode)
            2'b00: led_nx = db;
            2'b01: led_nx = t;
            2'b10: led_nx = blk;
            2'b11: led_nx = ~db;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            led <= '0;
        else
            led <= led_nx;
    end

endmodule
